// File: rtl/onehot_encoder_stream_if.sv
// Stream bundle for onehot_encoder_stream: request vector in, encoded index out.
// The slave modport is the encoder's view and the master modport is the producer/consumer's view.
interface onehot_encoder_stream_if #(
  parameter int WIDTH = 16,
  parameter int OUT_W = $clog2(WIDTH)
);
  // Handshake: a beat transfers on a rising edge where valid && ready. Once valid
  // is raised, the payload holds stable until that edge.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_code;
  logic             out_hit;
  logic             out_err;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_code, out_hit, out_err
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_code, out_hit, out_err
  );
endinterface

// File: rtl/onehot_encoder_stream.sv
// Registered one-hot/priority encoder with a valid/ready stream on both sides.
// It also keeps a saturating count of the accepted patterns that are invalid for MODE.
module onehot_encoder_stream #(
  parameter int WIDTH = 16,
  parameter int MODE  = 0,
  parameter int CNT_W = 8,
  localparam int OUT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot_encoder_stream_if.slave bus,
  output logic [CNT_W-1:0]     err_count,
  input  logic                 clr_err,
  output logic                 dbg_full
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } stage_e;

  stage_e           state;
  logic             accept;
  logic [OUT_W-1:0] lo_idx;
  logic [OUT_W-1:0] hi_idx;
  logic             multi_hot;
  logic             nxt_hit;
  logic             nxt_err;
  logic [OUT_W-1:0] nxt_code;

  assign bus.out_valid = (state == FULL);
  assign bus.in_ready  = (state == EMPTY) || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign dbg_full      = (state == FULL);

  // Both scans run every cycle. A zero vector leaves each index at 0.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (bus.in_data[i]) lo_idx = OUT_W'(i);
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.in_data[i]) hi_idx = OUT_W'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_hot = |(bus.in_data & (bus.in_data - WIDTH'(1)));
  assign nxt_hit   = |bus.in_data;

  always_comb begin
    nxt_code = lo_idx;
    nxt_err  = !nxt_hit;
    if (MODE == 0) begin
      nxt_err = !nxt_hit || multi_hot;
    end else if (MODE == 2) begin
      nxt_code = hi_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= EMPTY;
      bus.out_code <= '0;
      bus.out_hit  <= 1'b0;
      bus.out_err  <= 1'b0;
    end else if (accept) begin
      state        <= FULL;
      bus.out_code <= nxt_code;
      bus.out_hit  <= nxt_hit;
      bus.out_err  <= nxt_err;
    end else if (bus.out_ready) begin
      state <= EMPTY;
    end
  end

  // A clear takes priority over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (accept && nxt_err && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_onehot_encoder_stream.sv
// Directed bench for onehot_encoder_stream. Four instances share one stimulus stream:
// MODE 0, MODE 1, MODE 2, and MODE 0 with a 2-bit error counter.
module tb_onehot_encoder_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        clr_err;

  logic [7:0]  err_count0, err_count1, err_count2;
  logic [1:0]  err_count3;
  logic        dbg0, dbg1, dbg2, dbg3;

  int n_checks = 0;
  int n_fail   = 0;

  onehot_encoder_stream_if #(.WIDTH(16)) if0 ();
  onehot_encoder_stream_if #(.WIDTH(16)) if1 ();
  onehot_encoder_stream_if #(.WIDTH(16)) if2 ();
  onehot_encoder_stream_if #(.WIDTH(16)) if3 ();

  assign if0.in_valid = in_valid;  assign if0.in_data = in_data;  assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid;  assign if1.in_data = in_data;  assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid;  assign if2.in_data = in_data;  assign if2.out_ready = out_ready;
  assign if3.in_valid = in_valid;  assign if3.in_data = in_data;  assign if3.out_ready = out_ready;

  onehot_encoder_stream #(.WIDTH(16), .MODE(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave), .err_count(err_count0), .clr_err(clr_err), .dbg_full(dbg0));
  onehot_encoder_stream #(.WIDTH(16), .MODE(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .err_count(err_count1), .clr_err(clr_err), .dbg_full(dbg1));
  onehot_encoder_stream #(.WIDTH(16), .MODE(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave), .err_count(err_count2), .clr_err(clr_err), .dbg_full(dbg2));
  onehot_encoder_stream #(.WIDTH(16), .MODE(0), .CNT_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave), .err_count(err_count3), .clr_err(clr_err), .dbg_full(dbg3));

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference for MODE 0: returns {hit, err, code[3:0]}.
  function automatic logic [5:0] model0(input logic [15:0] d);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (d[i]) begin
        code = 4'(i);
        break;
      end
    end
    return {d != 16'h0, $countones(d) != 1, code};
  endfunction

  // Scoreboard for dut0 plus error-counter models for dut0 and dut3
  logic [5:0] exp_q[$];
  int exp_cnt0 = 0;
  int exp_cnt3 = 0;

  always @(negedge clk) begin
    logic [5:0] e;
    logic [5:0] m;
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt0 <= 0;
      exp_cnt3 <= 0;
    end else begin
      chk("err_count_m0", 32'(err_count0), 32'(exp_cnt0));
      chk("err_count_cnt2", 32'(err_count3), 32'(exp_cnt3));
      if (if0.out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_output", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sb_out_hit_err_code", 32'({if0.out_hit, if0.out_err, if0.out_code}), 32'(e));
        end
      end
      m = model0(in_data);
      if (in_valid && if0.in_ready) exp_q.push_back(m);
      if (clr_err) begin
        exp_cnt0 <= 0;
        exp_cnt3 <= 0;
      end else if (in_valid && if0.in_ready && m[4]) begin
        exp_cnt0 <= (exp_cnt0 == 255) ? 255 : exp_cnt0 + 1;
        exp_cnt3 <= (exp_cnt3 == 3) ? 3 : exp_cnt3 + 1;
      end
    end
  end

  typedef struct {
    logic [15:0] data;
    logic        hit;
    logic [3:0]  code0;
    logic        err0;
    logic [3:0]  code1;
    logic        err1;
    logic [3:0]  code2;
    logic        err2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [15:0] d, input logic h,
                              input logic [3:0] c0, input logic e0,
                              input logic [3:0] c1, input logic e1,
                              input logic [3:0] c2, input logic e2);
    vec_t v;
    v.data = d; v.hit = h;
    v.code0 = c0; v.err0 = e0;
    v.code1 = c1; v.err1 = e1;
    v.code2 = c2; v.err2 = e2;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic c);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr_err   = c;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);

    // Walking one, then invalid and priority patterns: {data, hit, m0, m1, m2}
    for (int k = 0; k < 16; k++)
      tbl.push_back(mk(16'h0001 << k, 1'b1, 4'(k), 1'b0, 4'(k), 1'b0, 4'(k), 1'b0));
    tbl.push_back(mk(16'h0000, 1'b0, 4'd0, 1'b1, 4'd0,  1'b1, 4'd0,  1'b1));
    tbl.push_back(mk(16'h0A00, 1'b1, 4'd9, 1'b1, 4'd9,  1'b0, 4'd11, 1'b0));
    tbl.push_back(mk(16'h8001, 1'b1, 4'd0, 1'b1, 4'd0,  1'b0, 4'd15, 1'b0));
    tbl.push_back(mk(16'hFFFF, 1'b1, 4'd0, 1'b1, 4'd0,  1'b0, 4'd15, 1'b0));
    tbl.push_back(mk(16'h0006, 1'b1, 4'd1, 1'b1, 4'd1,  1'b0, 4'd2,  1'b0));

    #2;
    chk("reset_in_ready", 32'(if0.in_ready), 32'(1));
    chk("reset_out_valid_all", 32'({if0.out_valid, if1.out_valid, if2.out_valid, if3.out_valid}), 32'(0));
    chk("reset_dbg_all", 32'({dbg0, dbg1, dbg2, dbg3}), 32'(0));
    chk("reset_out_fields", 32'({if0.out_code, if0.out_hit, if0.out_err}), 32'(0));
    chk("reset_err_counts", 32'({err_count0, err_count1, err_count2, err_count3}), 32'(0));
    tick();
    rst_n = 1'b1;

    // Back-to-back stream, one output per cycle
    for (int i = 0; i < tbl.size(); i++) begin
      drive(1'b1, tbl[i].data, 1'b1, 1'b0);
      tick();
      chk($sformatf("v%0d_valid", i), 32'({if0.out_valid, if1.out_valid, if2.out_valid}), 32'(3'b111));
      chk($sformatf("v%0d_m0", i), 32'({if0.out_hit, if0.out_err, if0.out_code}),
          32'({tbl[i].hit, tbl[i].err0, tbl[i].code0}));
      chk($sformatf("v%0d_m1", i), 32'({if1.out_hit, if1.out_err, if1.out_code}),
          32'({tbl[i].hit, tbl[i].err1, tbl[i].code1}));
      chk($sformatf("v%0d_m2", i), 32'({if2.out_hit, if2.out_err, if2.out_code}),
          32'({tbl[i].hit, tbl[i].err2, tbl[i].code2}));
    end

    // Hold FULL with five errors counted in MODE 0, then reset asynchronously
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    chk("full_before_reset", 32'({if0.out_valid, dbg0}), 32'(2'b11));
    chk("err_count_m0_is_5", 32'(err_count0), 32'(5));
    chk("err_count_m1_is_1", 32'(err_count1), 32'(1));
    chk("err_count_cnt2_sat", 32'(err_count3), 32'(3));
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(if0.out_valid), 32'(0));
    chk("async_rst_fields", 32'({if0.out_code, if0.out_hit, if0.out_err}), 32'(0));
    chk("async_rst_err_count", 32'({err_count0, err_count3}), 32'(0));
    chk("async_rst_in_ready", 32'(if0.in_ready), 32'(1));
    tick();
    rst_n = 1'b1;

    // Backpressure: 4 is held for three cycles, then 5 follows with no loss
    drive(1'b1, 16'h0010, 1'b1, 1'b0);
    tick();
    chk("bp_first_code", 32'({if0.out_valid, if0.out_code}), 32'({1'b1, 4'd4}));
    drive(1'b1, 16'h0020, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp_hold%0d_in_ready", c), 32'(if0.in_ready), 32'(0));
      chk($sformatf("bp_hold%0d_code", c), 32'({if0.out_valid, if0.out_code}), 32'({1'b1, 4'd4}));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(if0.in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    chk("bp_next_code", 32'({if0.out_valid, if0.out_code}), 32'({1'b1, 4'd5}));
    tick();
    chk("bp_drained", 32'(if0.out_valid), 32'(0));

    // Counter saturation on the 2-bit instance, then clear beating an increment
    drive(1'b0, 16'h0, 1'b1, 1'b1);
    tick();
    clr_err = 1'b0;
    chk("cnt_cleared", 32'({err_count0, err_count3}), 32'(0));
    for (int z = 0; z < 5; z++) begin
      drive(1'b1, 16'h0000, 1'b1, 1'b0);
      tick();
    end
    chk("cnt_sat_cnt2", 32'(err_count3), 32'(3));
    chk("cnt_m0_is_5", 32'(err_count0), 32'(5));
    chk("cnt_zero_m1_err", 32'({if1.out_err, if1.out_hit}), 32'(2'b10));
    chk("cnt_zero_m2_err", 32'({if2.out_err, if2.out_hit}), 32'(2'b10));
    drive(1'b1, 16'h0000, 1'b1, 1'b1);
    tick();
    chk("cnt_clr_wins", 32'({err_count0, err_count3}), 32'(0));
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    tick();
    chk("sb_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
